// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller and its slot counter.
package parking_pkg;
  localparam int SLOT_W           = 5;
  localparam int DEF_MAX_SLOTS    = 20;
  localparam int DEF_MIN_SLOTS    = 0;
  localparam int DEF_OPEN_TIMEOUT = 50;
  localparam int DEF_TIMER_W      = 8;

  typedef enum logic [2:0] {
    GATE_IDLE,
    GATE_OPEN,
    GATE_CLEARING,
    GATE_REPORT,
    GATE_HOLDOFF
  } gate_state_e;
endpackage

// File: rtl/parking_gate_controller_if.sv
// Sensor / slot-count / strobe bundle between the lot environment and the gate controller.
interface parking_gate_controller_if;
  import parking_pkg::*;

  logic              entry_req;
  logic              entry_pass;
  logic              exit_req;
  logic              exit_pass;
  logic [SLOT_W-1:0] slots;
  logic              entry;
  logic              exit;
  logic              entry_gate_open;
  logic              exit_gate_open;
  logic              lot_full;
  logic              entry_denied;

  modport master (
    output entry_req, entry_pass, exit_req, exit_pass, slots,
    input  entry, exit, entry_gate_open, exit_gate_open, lot_full, entry_denied
  );

  modport slave (
    input  entry_req, entry_pass, exit_req, exit_pass, slots,
    output entry, exit, entry_gate_open, exit_gate_open, lot_full, entry_denied
  );
endinterface

// File: rtl/parking_gate_fsm.sv
// One barrier: admit on req&&allow, track the pass sensor edges, request a strobe per passage.
// PARKING_GATE_TIMEOUT_EN adds an auto-close timer while waiting in OPEN.
module parking_gate_fsm
  import parking_pkg::*;
`ifdef PARKING_GATE_TIMEOUT_EN
#(
  parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int TIMER_W      = DEF_TIMER_W
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic pass,
  input  logic allow,
  input  logic grant,
  output logic gate_open,
  output logic strobe_req,
  output logic strobe
);
  gate_state_e state, state_nxt;
  logic pass_q, pass_rise, pass_fall, timed_out;

  assign pass_rise  = pass & ~pass_q;
  assign pass_fall  = ~pass & pass_q;
  assign strobe_req = (state == GATE_REPORT);

`ifdef PARKING_GATE_TIMEOUT_EN
  logic [TIMER_W-1:0] timer;

  // Fires on the last waiting cycle so the barrier is down exactly OPEN_TIMEOUT cycles after it rose.
  assign timed_out = (timer == TIMER_W'(OPEN_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                              timer <= '0;
    else if (state == GATE_OPEN && state_nxt == GATE_OPEN) timer <= timer + TIMER_W'(1);
    else                                                    timer <= '0;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      GATE_IDLE:     if (req && allow) state_nxt = GATE_OPEN;
      GATE_OPEN:     if (pass_rise)    state_nxt = GATE_CLEARING;
                     else if (timed_out) state_nxt = GATE_IDLE;
      GATE_CLEARING: if (pass_fall)    state_nxt = GATE_REPORT;
      GATE_REPORT:   if (grant)        state_nxt = GATE_HOLDOFF;
      GATE_HOLDOFF:                    state_nxt = GATE_IDLE;
      default:                         state_nxt = GATE_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so gate_open tracks OPEN/CLEARING exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= GATE_IDLE;
      pass_q    <= 1'b0;
      gate_open <= 1'b0;
      strobe    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pass_q    <= pass;
      gate_open <= (state_nxt == GATE_OPEN) || (state_nxt == GATE_CLEARING);
      strobe    <= (state == GATE_REPORT) && grant;
    end
  end
endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier pair feeding the slot counter; exit wins strobe arbitration.
// Build with PARKING_GATE_TIMEOUT_EN to auto-close barriers abandoned in OPEN.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int MAX_SLOTS    = DEF_MAX_SLOTS,
  parameter int MIN_SLOTS    = DEF_MIN_SLOTS,
  parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int TIMER_W      = DEF_TIMER_W
) (
  input  logic                      clk,
  input  logic                      reset,
  parking_gate_controller_if.slave  bus
);
  // A misconfigured instance keeps the entry barrier shut rather than miscount.
  localparam bit CFG_OK = ((MAX_SLOTS >> SLOT_W) == 0) && (MIN_SLOTS < MAX_SLOTS) &&
                          (OPEN_TIMEOUT > 0) && ((OPEN_TIMEOUT >> TIMER_W) == 0);

  logic full_now, entry_allow, entry_idle;
  logic entry_strobe_req, exit_strobe_req, entry_grant, exit_grant;

  assign full_now    = (bus.slots <= SLOT_W'(MIN_SLOTS));
  assign entry_allow = CFG_OK && !full_now;

  // Exit first; entry is granted only when exit is not asking, so strobes never coincide.
  assign exit_grant  = exit_strobe_req;
  assign entry_grant = entry_strobe_req & ~exit_strobe_req;

  parking_gate_fsm
`ifdef PARKING_GATE_TIMEOUT_EN
    #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .TIMER_W(TIMER_W))
`endif
  u_entry_fsm (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.entry_req),
    .pass       (bus.entry_pass),
    .allow      (entry_allow),
    .grant      (entry_grant),
    .gate_open  (bus.entry_gate_open),
    .strobe_req (entry_strobe_req),
    .strobe     (bus.entry)
  );

  parking_gate_fsm
`ifdef PARKING_GATE_TIMEOUT_EN
    #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .TIMER_W(TIMER_W))
`endif
  u_exit_fsm (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.exit_req),
    .pass       (bus.exit_pass),
    .allow      (1'b1),
    .grant      (exit_grant),
    .gate_open  (bus.exit_gate_open),
    .strobe_req (exit_strobe_req),
    .strobe     (bus.exit)
  );

  // Only IDLE has barrier down, no pending request and no strobe (HOLDOFF is the strobe cycle).
  assign entry_idle = ~(bus.entry_gate_open | entry_strobe_req | bus.entry);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.lot_full     <= 1'b0;
      bus.entry_denied <= 1'b0;
    end else begin
      bus.lot_full     <= full_now;
      bus.entry_denied <= entry_idle & bus.entry_req & full_now;
    end
  end
endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed cycle-exact checks of the gate controller against hand-computed timelines.
module tb_parking_gate_controller;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_gate_controller_if bus ();
  parking_gate_controller dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0, n_fail = 0;
  int entry_cnt = 0, exit_cnt = 0;
  bit both_seen = 1'b0;
  int e0, x0;

  always @(negedge clk) begin
    if (bus.entry === 1'b1) entry_cnt++;
    if (bus.exit === 1'b1) exit_cnt++;
    if (bus.entry === 1'b1 && bus.exit === 1'b1) both_seen = 1'b1;
  end

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task step();
    @(posedge clk);
    #1;
  endtask

  task quiet();
    bus.entry_req = 1'b0; bus.entry_pass = 1'b0;
    bus.exit_req  = 1'b0; bus.exit_pass  = 1'b0;
  endtask

  // Car drives under an already-open barrier and clears it; strobe lands inside the 5 trailing cycles.
  task run_pass(input bit ex);
    if (ex) bus.exit_pass = 1'b1; else bus.entry_pass = 1'b1;
    step(); step();
    if (ex) bus.exit_pass = 1'b0; else bus.entry_pass = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    quiet();
    bus.slots = 5'd20;
    reset = 1'b1;
    #1;
    chk("rst_entry_open", bus.entry_gate_open, 0);
    chk("rst_exit_open", bus.exit_gate_open, 0);
    chk("rst_strobes", {bus.entry, bus.exit}, 0);
    chk("rst_flags", {bus.lot_full, bus.entry_denied}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // 1: single uncontested entry, exact latency
    e0 = entry_cnt;
    bus.entry_req = 1'b1;                       // cycle c
    step(); chk("t1_open", bus.entry_gate_open, 1);
    chk("t1_lot_full", bus.lot_full, 0);
    bus.entry_req = 1'b0;                       // dropped in OPEN: stays open
    step(); chk("t1_open_held", bus.entry_gate_open, 1);
    bus.entry_pass = 1'b1;
    repeat (4) step();
    chk("t1_open_clearing", bus.entry_gate_open, 1);
    bus.entry_pass = 1'b0;                      // M
    step(); chk("t1_closed_m1", bus.entry_gate_open, 0);
    chk("t1_no_strobe_m1", bus.entry, 0);
    step(); chk("t1_strobe_m2", bus.entry, 1);
    step(); chk("t1_strobe_m3", bus.entry, 0);
    step(); chk("t1_count", entry_cnt - e0, 1);

    // 2: full lot denies, then admits once a slot frees
    e0 = entry_cnt;
    bus.slots = 5'd0;
    bus.entry_req = 1'b1;
    repeat (30) step();
    chk("t2_denied", bus.entry_denied, 1);
    chk("t2_lot_full", bus.lot_full, 1);
    chk("t2_closed", bus.entry_gate_open, 0);
    chk("t2_no_strobe", entry_cnt - e0, 0);
    bus.slots = 5'd1;
    step(); chk("t2_opens", bus.entry_gate_open, 1);
    chk("t2_denied_clr", bus.entry_denied, 0);
    chk("t2_full_clr", bus.lot_full, 0);
    bus.entry_req = 1'b0;
    run_pass(1'b0);
    chk("t2_count", entry_cnt - e0, 1);
    bus.slots = 5'd20;

    // 3: simultaneous completion, exit first
    e0 = entry_cnt; x0 = exit_cnt;
    bus.entry_req = 1'b1; bus.exit_req = 1'b1;
    step(); chk("t3_both_open", {bus.entry_gate_open, bus.exit_gate_open}, 2'b11);
    bus.entry_req = 1'b0; bus.exit_req = 1'b0;
    bus.entry_pass = 1'b1; bus.exit_pass = 1'b1;
    step(); step();
    bus.entry_pass = 1'b0; bus.exit_pass = 1'b0;   // M
    step(); chk("t3_m1", {bus.entry_gate_open, bus.exit_gate_open, bus.entry, bus.exit}, 0);
    step(); chk("t3_m2", {bus.entry, bus.exit}, 2'b01);
    step(); chk("t3_m3", {bus.entry, bus.exit}, 2'b10);
    step(); chk("t3_m4", {bus.entry, bus.exit}, 2'b00);
    chk("t3_counts", {16'(entry_cnt - e0), 16'(exit_cnt - x0)}, {16'd1, 16'd1});

    // 4: back-to-back entries with req held; strobes at t6 and t13 only
    for (int t = 0; t < 17; t++) begin
      bus.entry_req  = (t < 13);
      bus.entry_pass = (t == 2 || t == 3 || t == 9 || t == 10);
      step();
      chk($sformatf("t4_entry_c%0d", t + 1), bus.entry, (t + 1 == 6 || t + 1 == 13));
      chk($sformatf("t4_open_c%0d", t + 1), bus.entry_gate_open,
          ((t + 1 >= 1 && t + 1 <= 4) || (t + 1 >= 8 && t + 1 <= 11)));
    end
    quiet();
    step();

    // 5: abandoned barrier
    e0 = entry_cnt;
    bus.entry_req = 1'b1;
    step(); chk("t5_open", bus.entry_gate_open, 1);   // opening cycle t0
    bus.entry_req = 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
    repeat (49) step();
    chk("t5_open_t49", bus.entry_gate_open, 1);
    step(); chk("t5_closed_t50", bus.entry_gate_open, 0);
    repeat (3) step();
    chk("t5_no_strobe", entry_cnt - e0, 0);
`else
    repeat (200) step();
    chk("t5_open_t200", bus.entry_gate_open, 1);
    chk("t5_no_strobe", entry_cnt - e0, 0);
    run_pass(1'b0);
    chk("t5_late_pass", entry_cnt - e0, 1);
`endif

    // 6: reset during CLEARING aborts the passage
    bus.entry_req = 1'b1; bus.exit_req = 1'b1;
    step();
    bus.entry_req = 1'b0; bus.exit_req = 1'b0;
    bus.entry_pass = 1'b1; bus.exit_pass = 1'b1;
    step(); step();
    chk("t6_clearing_open", {bus.entry_gate_open, bus.exit_gate_open}, 2'b11);
    e0 = entry_cnt; x0 = exit_cnt;
    #2 reset = 1'b1;
    #1;
    chk("t6_async_gates", {bus.entry_gate_open, bus.exit_gate_open}, 0);
    chk("t6_async_strobes", {bus.entry, bus.exit}, 0);
    step(); step();
    reset = 1'b0;
    step();
    bus.entry_pass = 1'b0; bus.exit_pass = 1'b0;
    repeat (5) step();
    chk("t6_no_strobe", {16'(entry_cnt - e0), 16'(exit_cnt - x0)}, 0);
    chk("t6_gates_closed", {bus.entry_gate_open, bus.exit_gate_open}, 0);

    chk("never_both_strobes", both_seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Drives the entry/exit strobes consumed by the slot counter; the other end of the entry/exit pulse interface.
- Runs one barrier FSM per gate, using the vehicle sensors and the current `slots` value.
- Admits a car only when a slot is free.
- Emits exactly one clean single-cycle strobe per completed passage. Entry and exit strobes never coincide.

Parameters:
- MAX_SLOTS, 20, lot capacity; must match the counter's maximum.
- MIN_SLOTS, 0, slot floor; entry is refused when `slots <= MIN_SLOTS`.
- OPEN_TIMEOUT, 50, cycles a barrier waits for the car before auto-closing (only with the macro defined).
- TIMER_W, 8, timeout counter width; must satisfy 2^TIMER_W > OPEN_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- entry_req  in  1  level; car present at entry approach sensor.
- entry_pass  in  1  level; car under entry barrier sensor.
- exit_req  in  1  level; car present at exit approach sensor.
- exit_pass  in  1  level; car under exit barrier sensor.
- slots  in  5  free-slot count returned by the counter.
- entry  out  1  one-cycle strobe to the counter: one car entered.
- exit  out  1  one-cycle strobe to the counter: one car left.
- entry_gate_open  out  1  entry barrier open command.
- exit_gate_open  out  1  exit barrier open command.
- lot_full  out  1  registered flag, `slots <= MIN_SLOTS`.
- entry_denied  out  1  high while `entry_req` is held in IDLE and the lot is full.

Behaviour:
- Reset: one clock `clk`; asynchronous active-high `reset`. All outputs 0, both FSMs IDLE, timers 0, pass-sensor history 0.
- Every output is registered.
- Per-gate FSM states: IDLE, OPEN, CLEARING, REPORT, HOLDOFF.
- IDLE:
  - Entry gate: `entry_req && slots > MIN_SLOTS` -> OPEN; gate_open rises the next cycle.
  - Exit gate: `exit_req` -> OPEN unconditionally. Cars must always be able to leave; the counter saturates at MAX_SLOTS.
- OPEN: gate_open=1. Rising edge of pass (pass=1, previous=0) -> CLEARING.
- CLEARING: gate_open stays 1. Falling edge of pass -> REPORT, and gate_open drops that same transition.
- REPORT: raises a strobe request to the arbiter and waits until granted. On grant, the strobe is high for exactly one cycle, then -> HOLDOFF.
- HOLDOFF: one cycle. Guarantees at least one low cycle between same-line strobes (the counter is edge-detecting) and lets the updated `slots` settle before the next IDLE admission check. Then -> IDLE.
- Arbiter: if both gates are in REPORT together, exit is granted first and entry the next cycle. `entry && exit` is never 1 in the same cycle (the counter would drop one update).
- Latency (uncontested): pass falls at cycle M -> gate_open low at M+1 -> strobe high at M+2 only. With contention, the entry strobe moves to M+3.
- Entry denial: `entry_req` held while full keeps the FSM in IDLE with `entry_denied=1`. The gate opens automatically once `slots` rises above MIN_SLOTS.
- `entry_req` dropping in OPEN before pass: the gate stays open (timeout, if compiled in, handles abandonment).
- `pass` high while IDLE is ignored. Only the rising edge in OPEN counts, so a stuck sensor cannot generate strobes.
- Reset mid-passage: barriers close and no strobe is issued for the aborted passage.

Optional Feature:
- Macro: `PARKING_GATE_TIMEOUT_EN`.
- Defined:
  - In OPEN, the timer increments each cycle and clears on leaving OPEN.
  - Reaching OPEN_TIMEOUT with no pass rising edge -> IDLE: gate closes, no strobe.
  - CLEARING has no timeout.
- Undefined: no timer logic; OPEN waits indefinitely for the pass edge.

Decomposition:
- Shared package `parking_pkg`:
  - gate state encoding (IDLE/OPEN/CLEARING/REPORT/HOLDOFF);
  - slot width constant 5;
  - default MAX_SLOTS/MIN_SLOTS.
- Sub-module `parking_gate_fsm`:
  - ports: req/pass/allow/grant in, gate_open/strobe_req/strobe out;
  - instantiated twice, with `allow = slots > MIN_SLOTS` for entry and constant 1 for exit.
- Top: arbiter, `lot_full`/`entry_denied` flags, timeout hookup.

Test Plan:
1. `slots=20`, entry_req=1 at cycle 2 -> entry_gate_open=1 at 3; pass 1 at cycles 5–8, 0 at 9 -> gate_open=0 at 10, entry=1 at 11 only, entry=0 at 12.
2. `slots=0`, entry_req held 30 cycles -> entry_denied=1, lot_full=1, gate closed, no strobe. Then slots->1 -> gate opens the following cycle.
3. Both gates finish passage with pass falling in the same cycle M -> exit=1 at M+2, entry=1 at M+3, never both high.
4. Two back-to-back entry passages -> two separate one-cycle entry strobes with at least 1 low cycle between them.
5. With `PARKING_GATE_TIMEOUT_EN`, OPEN_TIMEOUT=50: open the entry gate with no pass -> gate closes at cycle 50 after opening, no strobe. Without the macro, still open at cycle 200.
6. `reset` asserted during CLEARING -> gates and strobes 0 immediately (asynchronous). After release, a pass falling edge produces no strobe.
